// File: rtl/register_bank_sb.sv
// register_bank_sb: register file with two registered read ports, one write
// port, per-register pending (scoreboard) bits that stall reads of registers
// awaiting a write, and N/Z/C flags captured from the most recent write.
module register_bank_sb #(
  parameter int WORD_LENGTH = 8,
  parameter int NUM_REGS    = 4,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_reg_en,
  input  logic [ADDR_W-1:0]      write_reg,
  input  logic [WORD_LENGTH-1:0] write_data,
  input  logic                   write_carry,
  input  logic                   read_en,
  input  logic [ADDR_W-1:0]      read_reg1,
  input  logic [ADDR_W-1:0]      read_reg2,
  output logic [WORD_LENGTH-1:0] read_data1,
  output logic [WORD_LENGTH-1:0] read_data2,
  output logic                   read_valid,
  input  logic                   reserve_en,
  input  logic [ADDR_W-1:0]      reserve_reg,
  output logic                   stall,
  output logic [2:0]             CZN_from_RF
);

  // Address decodes to a real register (NUM_REGS need not be a power of two).
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < NUM_REGS);
  endfunction

  logic [WORD_LENGTH-1:0] regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]    pending_r;
  logic [WORD_LENGTH-1:0] rd1_r;
  logic [WORD_LENGTH-1:0] rd2_r;
  logic                   valid_r;
  logic [2:0]             czn_r;

  logic                   wr_ok_s;
  logic                   rsv_ok_s;
  logic [NUM_REGS-1:0]    pend_eff_s;
  logic [NUM_REGS-1:0]    pend_nxt_s;
  logic                   hit1_s;
  logic                   hit2_s;
  logic                   stall_s;
  logic                   read_acc_s;
  logic [WORD_LENGTH-1:0] rd1_nxt_s;
  logic [WORD_LENGTH-1:0] rd2_nxt_s;

  // Scoreboard: a same-cycle write releases its register unless it is re-reserved.
  always_comb begin
    wr_ok_s    = write_reg_en && in_range(write_reg);
    rsv_ok_s   = reserve_en && in_range(reserve_reg);
    pend_eff_s = pending_r;
    if (wr_ok_s && !(rsv_ok_s && (reserve_reg == write_reg))) begin
      pend_eff_s[write_reg] = 1'b0;
    end else begin
      pend_eff_s = pending_r;
    end
    pend_nxt_s = pend_eff_s;
    if (rsv_ok_s) begin
      pend_nxt_s[reserve_reg] = 1'b1;
    end else begin
      pend_nxt_s = pend_eff_s;
    end
  end

  // Refuse a read while either source still waits on an outstanding write.
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    if (in_range(read_reg1)) begin
      hit1_s = pend_eff_s[read_reg1];
    end else begin
      hit1_s = 1'b0;
    end
    if (in_range(read_reg2)) begin
      hit2_s = pend_eff_s[read_reg2];
    end else begin
      hit2_s = 1'b0;
    end
    stall_s    = read_en && (hit1_s || hit2_s);
    read_acc_s = read_en && !stall_s;
  end

  // Read data selection with write-first bypass; unmapped addresses read zero.
  always_comb begin
    rd1_nxt_s = {WORD_LENGTH{1'b0}};
    rd2_nxt_s = {WORD_LENGTH{1'b0}};
    if (wr_ok_s && (write_reg == read_reg1)) begin
      rd1_nxt_s = write_data;
    end else if (in_range(read_reg1)) begin
      rd1_nxt_s = regs_r[read_reg1];
    end else begin
      rd1_nxt_s = {WORD_LENGTH{1'b0}};
    end
    if (wr_ok_s && (write_reg == read_reg2)) begin
      rd2_nxt_s = write_data;
    end else if (in_range(read_reg2)) begin
      rd2_nxt_s = regs_r[read_reg2];
    end else begin
      rd2_nxt_s = {WORD_LENGTH{1'b0}};
    end
  end

  // Register storage and pending bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {WORD_LENGTH{1'b0}};
      end
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      if (wr_ok_s) begin
        regs_r[write_reg] <= write_data;
      end
      pending_r <= pend_nxt_s;
    end
  end

  // Registered read port: data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_r   <= {WORD_LENGTH{1'b0}};
      rd2_r   <= {WORD_LENGTH{1'b0}};
      valid_r <= 1'b0;
    end else if (read_acc_s) begin
      rd1_r   <= rd1_nxt_s;
      rd2_r   <= rd2_nxt_s;
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  // Flags {N,Z,C} follow the last accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      czn_r <= 3'b000;
    end else if (wr_ok_s) begin
      czn_r <= {write_data[WORD_LENGTH-1], (write_data == {WORD_LENGTH{1'b0}}), write_carry};
    end else begin
      czn_r <= czn_r;
    end
  end

  assign read_data1  = rd1_r;
  assign read_data2  = rd2_r;
  assign read_valid  = valid_r;
  assign stall       = stall_s;
  assign CZN_from_RF = czn_r;

endmodule
